// File: rtl/cam_pkg.sv
// cam_pkg: command encoding shared by the ternary CAM and its bench
package cam_pkg;
  typedef enum logic [1:0] {
    CAM_READ,
    CAM_WRITE,
    CAM_INVALIDATE,
    CAM_FLUSH
  } CAM_CMD;
endpackage

// File: rtl/cam_ternary_if.sv
// cam_ternary_if: command and lookup/occupancy bundle of the ternary CAM
interface cam_ternary_if #(parameter int SIZE = 8, parameter int WIDTH = 32);
  import cam_pkg::*;
  localparam int IDX_W = SIZE > 1 ? $clog2(SIZE) : 1;
  logic enable;
  CAM_CMD command;
  logic [IDX_W-1:0] write_idx;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] mask;
  logic hit;
  logic [IDX_W-1:0] read_idx;
  logic multi_hit;
  logic [IDX_W:0] valid_count;
  logic full;
  logic [IDX_W-1:0] free_idx;
  logic free_valid;
  modport master(
    output enable, command, write_idx, data, mask,
    input hit, read_idx, multi_hit, valid_count, full, free_idx, free_valid
  );
  modport slave(
    input enable, command, write_idx, data, mask,
    output hit, read_idx, multi_hit, valid_count, full, free_idx, free_valid
  );
endinterface

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-set-bit index plus any/multiple-set flags
module cam_prio_enc #(
  parameter int N = 8,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);
  // scan from the top so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign any   = |req;
  assign multi = |(req & (req - N'(1)));
endmodule

// File: rtl/cam_ternary.sv
// cam_ternary: ternary CAM with registered lookup, occupancy count and free-slot finder
module cam_ternary import cam_pkg::*; #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  cam_ternary_if.slave bus
);
  localparam int IDX_W = SIZE > 1 ? $clog2(SIZE) : 1;
  logic [SIZE-1:0] valid, match;
  logic [WIDTH-1:0] key [SIZE];
  logic [WIDTH-1:0] care [SIZE];
  logic [IDX_W:0] count;
  logic [IDX_W-1:0] read_idx, match_idx, free_idx;
  logic hit, multi_hit, match_any, match_multi, free_any, unused_free_multi;
  logic in_range, do_rd, do_wr, do_inv, do_flush;
  assign in_range = 32'(bus.write_idx) < SIZE;
  assign do_rd    = bus.enable && bus.command == CAM_READ;
  assign do_wr    = bus.enable && bus.command == CAM_WRITE && in_range;
  assign do_inv   = bus.enable && bus.command == CAM_INVALIDATE && in_range;
  assign do_flush = bus.enable && bus.command == CAM_FLUSH;
  // per-entry ternary compare; search data is used unmasked
  always_comb begin
    match = '0;
    for (int e = 0; e < SIZE; e++) match[e] = valid[e] && ((key[e] ^ bus.data) & care[e]) == '0;
  end
  cam_prio_enc #(.N(SIZE)) u_match (.req(match), .idx(match_idx), .any(match_any), .multi(match_multi));
  cam_prio_enc #(.N(SIZE)) u_free (.req(~valid), .idx(free_idx), .any(free_any), .multi(unused_free_multi));
  // key/care payload is never reset; only the valid bits qualify it
  always_ff @(posedge clock) begin
    if (!reset && do_wr) begin
      key[bus.write_idx]  <= bus.data;
      care[bus.write_idx] <= bus.mask;
    end
  end
  // valid bits, occupancy count and registered lookup result
  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= '0;
      count     <= '0;
      hit       <= 1'b0;
      multi_hit <= 1'b0;
      read_idx  <= '0;
    end else begin
      if (do_flush) begin
        valid <= '0;
        count <= '0;
      end else if (do_wr && !valid[bus.write_idx]) begin
        valid[bus.write_idx] <= 1'b1;
        count <= count + 1'b1;
      end else if (do_inv && valid[bus.write_idx]) begin
        valid[bus.write_idx] <= 1'b0;
        count <= count - 1'b1;
      end
      hit       <= do_rd && match_any;
      multi_hit <= do_rd && match_multi;
      if (do_rd && match_any) read_idx <= match_idx;
    end
  end
  assign bus.hit         = hit;
  assign bus.multi_hit   = multi_hit;
  assign bus.read_idx    = read_idx;
  assign bus.valid_count = count;
  assign bus.full        = count == (IDX_W + 1)'(SIZE);
  assign bus.free_idx    = free_idx;
  assign bus.free_valid  = free_any;
endmodule

// File: tb/tb_cam_ternary.sv
// tb_cam_ternary: directed table, randomized model comparison and SIZE=6 corner sequence
module tb_cam_ternary;
  import cam_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8 = 1'b1, rst6 = 1'b1;
  cam_ternary_if #(.SIZE(8), .WIDTH(32)) b8();
  cam_ternary_if #(.SIZE(6), .WIDTH(32)) b6();
  cam_ternary #(.SIZE(8), .WIDTH(32)) dut8 (.clock(clk), .reset(rst8), .bus(b8));
  cam_ternary #(.SIZE(6), .WIDTH(32)) dut6 (.clock(clk), .reset(rst6), .bus(b6));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // reference model for the SIZE=8 instance: plain arrays, count derived by summing
  bit mv[8];
  logic [31:0] mk[8], mc[8];
  bit e_hit, e_multi;
  int e_idx;

  function automatic int m_cnt();
    int n = 0;
    for (int e = 0; e < 8; e++) n += int'(mv[e]);
    return n;
  endfunction

  function automatic int m_free();
    for (int e = 0; e < 8; e++) if (!mv[e]) return e;
    return 0;
  endfunction

  task automatic step8(input bit r, input bit en, input CAM_CMD c, input int idx,
                       input logic [31:0] d, input logic [31:0] m);
    int n, low;
    rst8 = r; b8.enable = en; b8.command = c; b8.write_idx = 3'(idx); b8.data = d; b8.mask = m;
    if (r) begin
      for (int e = 0; e < 8; e++) mv[e] = 0;
      e_hit = 0; e_multi = 0; e_idx = 0;
    end else begin
      n = 0; low = -1;
      if (en && c == CAM_READ)
        for (int e = 0; e < 8; e++)
          if (mv[e] && ((mk[e] ^ d) & mc[e]) == 0) begin
            n++;
            if (low < 0) low = e;
          end
      e_hit = n > 0; e_multi = n > 1;
      if (n > 0) e_idx = low;
      if (en && c == CAM_WRITE && idx < 8) begin mv[idx] = 1; mk[idx] = d; mc[idx] = m; end
      if (en && c == CAM_INVALIDATE && idx < 8) mv[idx] = 0;
      if (en && c == CAM_FLUSH) for (int e = 0; e < 8; e++) mv[e] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_hit"}, 32'(b8.hit), 32'(e_hit));
    chk({tag, "_multi"}, 32'(b8.multi_hit), 32'(e_multi));
    chk({tag, "_ridx"}, 32'(b8.read_idx), 32'(e_idx));
    chk({tag, "_cnt"}, 32'(b8.valid_count), 32'(m_cnt()));
    chk({tag, "_full"}, 32'(b8.full), 32'(m_cnt() == 8));
    chk({tag, "_free"}, 32'(b8.free_idx), 32'(m_free()));
    chk({tag, "_fvalid"}, 32'(b8.free_valid), 32'(m_cnt() != 8));
  endtask

  task automatic step6(input bit r, input bit en, input CAM_CMD c, input int idx, input logic [31:0] d);
    rst6 = r; b6.enable = en; b6.command = c; b6.write_idx = 3'(idx); b6.data = d; b6.mask = '1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit en; CAM_CMD cmd; int idx; logic [31:0] d, m;
    bit hit; int ridx; bit multi; int cnt; bit full; int free;
  } vec_t;
  vec_t tv[$];

  initial begin
    b6.enable = 0; b6.command = CAM_READ; b6.write_idx = 0; b6.data = 0; b6.mask = 0;
    tv.push_back('{1, CAM_READ, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 8; i++)
      tv.push_back('{1, CAM_WRITE, i, i, '1, 0, 0, 0, i + 1, i == 7, i == 7 ? 0 : i + 1});
    tv.push_back('{1, CAM_READ, 0, 5, 0, 1, 5, 0, 8, 1, 0});
    tv.push_back('{1, CAM_READ, 0, 8, 0, 0, 5, 0, 8, 1, 0});
    tv.push_back('{1, CAM_WRITE, 3, 32'h1230, 32'hFFFFFFF0, 0, 5, 0, 8, 1, 0});
    tv.push_back('{1, CAM_READ, 0, 32'h1237, 0, 1, 3, 0, 8, 1, 0});
    tv.push_back('{1, CAM_READ, 0, 32'h1247, 0, 0, 3, 0, 8, 1, 0});
    tv.push_back('{1, CAM_WRITE, 6, 32'hDEAD, '1, 0, 3, 0, 8, 1, 0});
    tv.push_back('{1, CAM_WRITE, 1, 32'hDEAD, '1, 0, 3, 0, 8, 1, 0});
    tv.push_back('{1, CAM_READ, 0, 32'hDEAD, 0, 1, 1, 1, 8, 1, 0});
    tv.push_back('{1, CAM_INVALIDATE, 1, 0, 0, 0, 1, 0, 7, 0, 1});
    tv.push_back('{1, CAM_READ, 0, 32'hDEAD, 0, 1, 6, 0, 7, 0, 1});
    tv.push_back('{1, CAM_FLUSH, 0, 0, 0, 0, 6, 0, 0, 0, 0});
    tv.push_back('{1, CAM_READ, 0, 32'hDEAD, 0, 0, 6, 0, 0, 0, 0});
    tv.push_back('{0, CAM_WRITE, 2, 32'h22, '1, 0, 6, 0, 0, 0, 0});
    tv.push_back('{1, CAM_INVALIDATE, 2, 0, 0, 0, 6, 0, 0, 0, 0});
    tv.push_back('{1, CAM_WRITE, 4, 32'hAB, 32'h0, 0, 6, 0, 1, 0, 0});
    tv.push_back('{1, CAM_READ, 0, 32'h12345, 0, 1, 4, 0, 1, 0, 0});
    tv.push_back('{0, CAM_READ, 0, 32'h12345, 0, 0, 4, 0, 1, 0, 0});

    step8(1, 1, CAM_READ, 0, 0, 0);
    check_model("reset");
    chk("reset_cnt_const", 32'(b8.valid_count), 0);
    chk("reset_fvalid_const", 32'(b8.free_valid), 1);
    foreach (tv[i]) begin
      step8(0, tv[i].en, tv[i].cmd, tv[i].idx, tv[i].d, tv[i].m);
      chk($sformatf("v%0d_hit", i), 32'(b8.hit), 32'(tv[i].hit));
      chk($sformatf("v%0d_ridx", i), 32'(b8.read_idx), 32'(tv[i].ridx));
      chk($sformatf("v%0d_multi", i), 32'(b8.multi_hit), 32'(tv[i].multi));
      chk($sformatf("v%0d_cnt", i), 32'(b8.valid_count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(b8.full), 32'(tv[i].full));
      chk($sformatf("v%0d_free", i), 32'(b8.free_idx), 32'(tv[i].free));
      chk($sformatf("v%0d_fvalid", i), 32'(b8.free_valid), 32'(!tv[i].full));
    end

    for (int i = 0; i < 400; i++) begin
      int p;
      CAM_CMD c;
      p = $urandom_range(0, 19);
      c = p < 8 ? CAM_READ : p < 15 ? CAM_WRITE : p < 19 ? CAM_INVALIDATE : CAM_FLUSH;
      step8($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, c, $urandom_range(0, 7),
            32'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0 ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : 32'hFFFFFFFF);
      check_model($sformatf("r%0d", i));
    end
    b8.enable = 0;

    step6(1, 1, CAM_WRITE, 0, 0);
    chk("s6_reset_cnt", 32'(b6.valid_count), 0);
    chk("s6_reset_fvalid", 32'(b6.free_valid), 1);
    step6(0, 1, CAM_WRITE, 2, 32'h55);
    chk("s6_w2_cnt", 32'(b6.valid_count), 1);
    chk("s6_w2_free", 32'(b6.free_idx), 0);
    step6(0, 1, CAM_WRITE, 7, 32'h77);
    chk("s6_w7_cnt", 32'(b6.valid_count), 1);
    step6(0, 1, CAM_INVALIDATE, 6, 0);
    chk("s6_inv6_cnt", 32'(b6.valid_count), 1);
    step6(0, 1, CAM_READ, 0, 32'h77);
    chk("s6_rd77_hit", 32'(b6.hit), 0);
    step6(0, 1, CAM_READ, 0, 32'h55);
    chk("s6_rd55_hit", 32'(b6.hit), 1);
    chk("s6_rd55_ridx", 32'(b6.read_idx), 2);
    for (int i = 0; i < 6; i++) step6(0, 1, CAM_WRITE, i, 32'h100 + 32'(i));
    chk("s6_fill_cnt", 32'(b6.valid_count), 6);
    chk("s6_fill_full", 32'(b6.full), 1);
    chk("s6_fill_fvalid", 32'(b6.free_valid), 0);
    chk("s6_fill_free", 32'(b6.free_idx), 0);
    step6(0, 1, CAM_READ, 0, 32'h105);
    chk("s6_rd105_ridx", 32'(b6.read_idx), 5);
    step6(1, 1, CAM_WRITE, 0, 32'h999);
    chk("s6_rstw_cnt", 32'(b6.valid_count), 0);
    chk("s6_rstw_hit", 32'(b6.hit), 0);
    chk("s6_rstw_ridx", 32'(b6.read_idx), 0);
    chk("s6_rstw_full", 32'(b6.full), 0);
    step6(0, 1, CAM_READ, 0, 32'h999);
    chk("s6_rd999_hit", 32'(b6.hit), 0);
    chk("s6_rd999_multi", 32'(b6.multi_hit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cam_ternary.md
Name: cam_ternary

Overview:
Parametrised successor to the team's binary CAM. It adds configurable key width, per-entry ternary (don't-care) masks, explicit invalidate and flush, multi-hit detection, occupancy tracking and a free-slot finder. Lookup results are registered with a fixed latency of one cycle. It serves as the match/allocate structure for tag stores and rename/dependency tables.

Parameters:
SIZE, 8, number of entries; any value >= 2, need not be a power of two.
WIDTH, 32, key/data width in bits.
IDX_W, $clog2(SIZE) (minimum 1), index width (localparam, not overridable).

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; dominates all other inputs.
enable  input  1  command qualifier; when 0 the array, count and lookup outputs behave as for a non-READ cycle.
command  input  CAM_CMD  CAM_READ / CAM_WRITE / CAM_INVALIDATE / CAM_FLUSH.
write_idx  input  IDX_W  target entry for WRITE/INVALIDATE.
data  input  WIDTH  key to store (WRITE) or search (READ).
mask  input  WIDTH  care mask stored with WRITE; bit 1 = compare, bit 0 = don't care.
hit  output  1  registered: last enabled READ matched at least one entry.
read_idx  output  IDX_W  registered: lowest matching index.
multi_hit  output  1  registered: more than one entry matched.
valid_count  output  IDX_W+1  registered number of valid entries.
full  output  1  valid_count == SIZE.
free_idx  output  IDX_W  lowest invalid index; 0 when full.
free_valid  output  1  at least one invalid entry (= !full).

Behaviour:
- Storage per entry: valid bit, key[WIDTH], care[WIDTH]. Only the valid bits are reset; key and care are not.
- Match condition for entry e: valid[e] && (((key[e] ^ data) & care[e]) == 0). The search data is not masked.
- Reset (synchronous): all valid bits = 0, hit = 0, multi_hit = 0, read_idx = 0, valid_count = 0. Consequently full = 0, free_idx = 0, free_valid = 1. Reset asserted mid-stream discards that cycle's command.
- Enabled CAM_WRITE:
  - If write_idx < SIZE: key = data, care = mask, valid = 1.
  - valid_count increments only if the entry was previously invalid.
  - If write_idx >= SIZE: no effect.
- Enabled CAM_INVALIDATE: valid[write_idx] = 0. valid_count decrements only if the entry was valid. An out-of-range index is a no-op.
- Enabled CAM_FLUSH: all valid bits = 0; valid_count = 0.
- Enabled CAM_READ:
  - At the edge, hit = any match, read_idx = lowest matching index, multi_hit = (match count > 1).
  - If there is no match: hit = 0, multi_hit = 0, read_idx holds its previous value.
- Lookup latency is one cycle. A READ sampled at edge t is searched against array state as it was before edge t. A WRITE at edge t is visible to a READ sampled at edge t+1.
- On any cycle that is not an enabled READ: hit = 0, multi_hit = 0, read_idx holds its previous value.
- full, free_idx and free_valid are combinational from the registered valid bits and valid_count, so they reflect the state after the most recent edge.
- Only one command per cycle, so there are no simultaneous-event conflicts inside the block.

Decomposition:
- cam_pkg: typedef enum CAM_CMD {CAM_READ, CAM_WRITE, CAM_INVALIDATE, CAM_FLUSH}; shared by RTL and bench.
- Sub-module cam_prio_enc #(N), purely combinational: N-bit request vector in; lowest-set index, any and multi out.
- cam_prio_enc is instantiated twice: once on the match vector, once on the inverted valid vector (free finder).

Test Plan:
1. SIZE=8, WIDTH=32. Reset, then enabled READ with data=0 -> next edge hit=0, multi_hit=0, valid_count=0, free_idx=0, free_valid=1, full=0.
2. WRITE idx i, data=i, mask=32'hFFFFFFFF for i=0..7:
   - After the loop: valid_count=8, full=1, free_valid=0.
   - READ 5 -> hit=1, read_idx=5, multi_hit=0.
   - READ 8 -> hit=0.
3. Ternary match:
   - WRITE idx 3, data=32'h1230, mask=32'hFFFFFFF0.
   - READ 32'h1237 -> hit=1, read_idx=3.
   - READ 32'h1247 -> hit=0.
4. Multi-hit and invalidate:
   - WRITE 32'hDEAD (full mask) to idx 6, then idx 1.
   - READ 32'hDEAD -> hit=1, read_idx=1, multi_hit=1.
   - INVALIDATE idx 1 -> valid_count=7, free_idx=1.
   - READ 32'hDEAD -> read_idx=6, multi_hit=0.
5. Flush and disable:
   - FLUSH -> valid_count=0, free_idx=0.
   - READ 32'hDEAD -> hit=0.
   - enable=0 with WRITE idx 2 -> valid_count stays 0.
6. SIZE=6 build:
   - WRITE idx 7 -> valid_count unchanged.
   - Assert reset in the same cycle as a WRITE idx 0 -> entry 0 stays invalid, all outputs take reset values.
